unidade_controle_exibicao: RTL and testbench

Sequencing controller that plays back the stored memory-game sequence on the LEDs at the start of each round. It drives the memory address, latches each stored value onto the LEDs for a fixed on-time, blanks them for a fixed off-time, advances, and signals completion so the main game control unit can hand the round over to the player. It sits between the game control unit (which starts it) and the datapath's sequence memory. The memory is read combinationally from `endereco`.

---
 rtl/unidade_controle_exibicao_pkg.sv | 25 ++
 rtl/unidade_controle_exibicao_contador_tempo.sv | 23 ++
 rtl/unidade_controle_exibicao.sv | 91 +++++++++
 tb/tb_unidade_controle_exibicao.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/unidade_controle_exibicao_pkg.sv
// Shared definitions for the sequence playback controller: state codes
// (also shown on the debug display) and default LED timings.
package unidade_controle_exibicao_pkg;

  typedef enum logic [3:0] {
    INICIAL = 4'h0,
    CARREGA = 4'h1,
    ACESO   = 4'h2,
    APAGADO = 4'h3,
    PROXIMO = 4'h4,
    FIM     = 4'hF
  } estado_t;

  localparam int unsigned T_ACESO_PADRAO   = 1000;
  localparam int unsigned T_APAGADO_PADRAO = 500;

  // Timer width: clog2 of the longer interval, never below one bit.
  function automatic int unsigned largura_timer(input int unsigned a, input int unsigned b);
    int unsigned maior;
    maior = (a > b) ? a : b;
    if (maior <= 1) return 1;
    return $clog2(maior);
  endfunction

endpackage

// File: rtl/unidade_controle_exibicao_contador_tempo.sv
// Up-counter with synchronous clear and enable; fim flags the terminal value,
// which is supplied at run time so one counter serves both LED intervals.
module contador_tempo #(
  parameter int unsigned LARGURA = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               limpa,
  input  logic               conta,
  input  logic [LARGURA-1:0] limite,
  output logic [LARGURA-1:0] valor,
  output logic               fim
);

  always_ff @(posedge clock) begin
    if (!reset)     valor <= '0;
    else if (limpa) valor <= '0;
    else if (conta) valor <= valor + LARGURA'(1);
  end

  assign fim = (valor == limite);

endmodule

// File: rtl/unidade_controle_exibicao.sv
// Plays back the stored game sequence on the LEDs: loads each item, holds it
// for T_ACESO cycles, blanks for T_APAGADO cycles, then advances or finishes.
module unidade_controle_exibicao
  import unidade_controle_exibicao_pkg::*;
#(
  parameter int unsigned T_ACESO   = T_ACESO_PADRAO,
  parameter int unsigned T_APAGADO = T_APAGADO_PADRAO
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       cancela,
  input  logic [3:0] rodada,
  input  logic [3:0] memoria,
  output logic [3:0] endereco,
  output logic [3:0] leds,
  output logic       ocupado,
  output logic       pronto,
  output logic [3:0] db_estado
);

  localparam int unsigned W = largura_timer(T_ACESO, T_APAGADO);
  localparam logic [W-1:0] FIM_ACESO   = W'(T_ACESO - 1);
  localparam logic [W-1:0] FIM_APAGADO = W'(T_APAGADO - 1);

  estado_t    estado, proximo;
  logic [3:0] limite;
  logic [W-1:0] tempo, alvo;
  logic       fim_tempo, limpa, conta, aborta;

  assign aborta = cancela && (estado != INICIAL);
  assign conta  = (estado == ACESO) || (estado == APAGADO);
  // Clearing on the terminal count restarts the timer for the off-interval.
  assign limpa  = aborta || !conta || fim_tempo;
  assign alvo   = (estado == APAGADO) ? FIM_APAGADO : FIM_ACESO;

  contador_tempo #(.LARGURA(W)) u_tempo (
    .clock  (clock),
    .reset  (reset),
    .limpa  (limpa),
    .conta  (conta),
    .limite (alvo),
    .valor  (tempo),
    .fim    (fim_tempo)
  );

  always_comb begin
    proximo = estado;
    unique case (estado)
      INICIAL: if (iniciar) proximo = CARREGA;
      CARREGA: proximo = ACESO;
      ACESO:   if (fim_tempo) proximo = APAGADO;
      APAGADO: if (fim_tempo) proximo = (endereco == limite) ? FIM : PROXIMO;
      PROXIMO: proximo = CARREGA;
      FIM:     proximo = INICIAL;
      default: proximo = INICIAL;
    endcase
    if (aborta) proximo = INICIAL;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      estado   <= INICIAL;
      endereco <= '0;
      leds     <= '0;
      limite   <= '0;
    end else begin
      estado <= proximo;
      if (aborta) begin
        leds     <= '0;
        endereco <= '0;
      end else begin
        unique case (estado)
          INICIAL: if (iniciar) limite <= rodada;
          CARREGA: leds <= memoria;
          ACESO:   if (fim_tempo) leds <= '0;
          PROXIMO: endereco <= endereco + 4'd1;
          FIM:     endereco <= '0;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    ocupado   = (estado != INICIAL);
    pronto    = (estado == FIM);
    db_estado = estado;
  end

endmodule

// File: tb/tb_unidade_controle_exibicao.sv
// Bench for the playback controller: a timing model derived from item
// period arithmetic is compared every cycle, plus literal spot checks.
module tb_unidade_controle_exibicao;

  logic       clock = 1'b0;
  logic       reset, iniciar, cancela, iniciar1, cancela1;
  logic [3:0] rodada, rodada1;
  logic [3:0] mem [16];
  logic [3:0] memoria0, endereco0, leds0, db0;
  logic       ocupado0, pronto0;
  logic [3:0] memoria1, endereco1, leds1, db1;
  logic       ocupado1, pronto1;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  always #5 clock = ~clock;

  assign memoria0 = mem[endereco0];
  assign memoria1 = mem[endereco1];

  unidade_controle_exibicao #(.T_ACESO(3), .T_APAGADO(2)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .cancela(cancela),
    .rodada(rodada), .memoria(memoria0), .endereco(endereco0), .leds(leds0),
    .ocupado(ocupado0), .pronto(pronto0), .db_estado(db0)
  );

  unidade_controle_exibicao #(.T_ACESO(1), .T_APAGADO(1)) dut1 (
    .clock(clock), .reset(reset), .iniciar(iniciar1), .cancela(cancela1),
    .rodada(rodada1), .memoria(memoria1), .endereco(endereco1), .leds(leds1),
    .ocupado(ocupado1), .pronto(pronto1), .db_estado(db1)
  );

  typedef struct packed {
    logic [3:0] leds;
    logic [3:0] endereco;
    logic [3:0] db;
    logic       ocupado;
    logic       pronto;
  } exp_t;

  // Model state: playing flag, cycle index of first CARREGA, item count.
  bit busy0 = 0, busy1 = 0;
  int base0 = 0, base1 = 0, n0 = 1, n1 = 1;

  function automatic exp_t modelo(input int c, input int base, input int n,
                                  input bit busy, input int ta, input int tp);
    exp_t e;
    int p, rel, i, ph;
    e = '0;
    if (!busy) return e;
    p   = ta + tp + 2;
    rel = c - base;
    i   = rel / p;
    ph  = rel % p;
    e.ocupado  = 1'b1;
    e.endereco = 4'(i);
    if (ph == 0) e.db = 4'h1;
    else if (ph <= ta) begin
      e.db   = 4'h2;
      e.leds = mem[i];
    end else if (ph <= ta + tp) e.db = 4'h3;
    else if (i == n - 1) begin
      e.db     = 4'hF;
      e.pronto = 1'b1;
    end else e.db = 4'h4;
    return e;
  endfunction

  always @(posedge clock) begin
    if (!reset) busy0 = 0;
    else if (busy0) begin
      if (cancela || (cyc - base0) == n0 * 7 - 1) busy0 = 0;
    end else if (iniciar) begin
      busy0 = 1;
      base0 = cyc + 1;
      n0    = int'(rodada) + 1;
    end
    if (!reset) busy1 = 0;
    else if (busy1) begin
      if (cancela1 || (cyc - base1) == n1 * 4 - 1) busy1 = 0;
    end else if (iniciar1) begin
      busy1 = 1;
      base1 = cyc + 1;
      n1    = int'(rodada1) + 1;
    end
    cyc = cyc + 1;
  end

  task automatic chk(input string nome, input logic [3:0] atual, input logic [3:0] esperado);
    compared++;
    if (atual !== esperado) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nome, atual, esperado, cyc);
    end
  endtask

  always @(negedge clock) begin
    exp_t e0, e1;
    e0 = modelo(cyc, base0, n0, busy0, 3, 2);
    e1 = modelo(cyc, base1, n1, busy1, 1, 1);
    chk("leds", leds0, e0.leds);
    chk("endereco", endereco0, e0.endereco);
    chk("db_estado", db0, e0.db);
    chk("ocupado", {3'b0, ocupado0}, {3'b0, e0.ocupado});
    chk("pronto", {3'b0, pronto0}, {3'b0, e0.pronto});
    chk("leds1", leds1, e1.leds);
    chk("endereco1", endereco1, e1.endereco);
    chk("db_estado1", db1, e1.db);
    chk("ocupado1", {3'b0, ocupado1}, {3'b0, e1.ocupado});
    chk("pronto1", {3'b0, pronto1}, {3'b0, e1.pronto});
  end

  logic [3:0] lit2 [6]  = '{4'h5, 4'h5, 4'h5, 4'h0, 4'h0, 4'h0};
  logic [3:0] lit3 [21] = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0,
                            4'h0, 4'h2, 4'h2, 4'h2, 4'h0, 4'h0, 4'h0,
                            4'h0, 4'h4, 4'h4, 4'h4, 4'h0, 4'h0, 4'h0};

  initial begin
    reset = 1'b0; iniciar = 1'b1; cancela = 1'b0; rodada = 4'd0;
    iniciar1 = 1'b0; cancela1 = 1'b0; rodada1 = 4'd0;
    for (int i = 0; i < 16; i++) mem[i] = 4'h0;

    // reset held with iniciar high
    repeat (2) @(negedge clock);
    chk("rst_db", db0, 4'h0);
    chk("rst_ocupado", {3'b0, ocupado0}, 4'h0);
    reset = 1'b1; iniciar = 1'b0;
    @(negedge clock);

    // single item
    mem[0] = 4'h5; rodada = 4'd0; iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
    chk("t2_carrega", db0, 4'h1);
    for (int r = 1; r <= 6; r++) begin
      @(negedge clock);
      chk("t2_leds", leds0, lit2[r-1]);
      chk("t2_endereco", endereco0, 4'h0);
    end
    chk("t2_pronto", {3'b0, pronto0}, 4'h1);
    @(negedge clock);
    chk("t2_ocupado_cai", {3'b0, ocupado0}, 4'h0);

    // three items, with iniciar and rodada disturbed mid-play
    mem[0] = 4'h1; mem[1] = 4'h2; mem[2] = 4'h4; rodada = 4'd2; iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
    for (int r = 1; r <= 20; r++) begin
      @(negedge clock);
      if (r == 2) rodada = 4'd9;
      if (r == 3) iniciar = 1'b1;
      if (r == 4) iniciar = 1'b0;
      chk("t3_leds", leds0, lit3[r]);
      if (r == 8)  chk("t3_end1", endereco0, 4'h1);
      if (r == 15) chk("t3_end2", endereco0, 4'h2);
    end
    chk("t3_pronto", {3'b0, pronto0}, 4'h1);
    @(negedge clock);
    rodada = 4'd2;

    // restart on first idle cycle, then cancel in item 1's on-time
    iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
    repeat (9) @(negedge clock);
    chk("t4_item1", leds0, 4'h2);
    cancela = 1'b1;
    @(negedge clock);
    chk("t4_cancel_db", db0, 4'h0);
    chk("t4_cancel_end", endereco0, 4'h0);
    chk("t4_cancel_leds", leds0, 4'h0);
    @(negedge clock);
    chk("t4_cancel_idle", db0, 4'h0);
    iniciar = 1'b1;
    @(negedge clock);
    chk("t4_iniciar_vence", db0, 4'h1);
    iniciar = 1'b0; cancela = 1'b0;
    repeat (22) @(negedge clock);

    // reset mid-playback
    iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
    repeat (10) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("t5_reset_db", db0, 4'h0);
    reset = 1'b1;
    @(negedge clock);

    // sixteen items at minimum timing
    for (int i = 0; i < 16; i++) mem[i] = 4'((i % 15) + 1);
    rodada1 = 4'd15; iniciar1 = 1'b1;
    @(negedge clock);
    iniciar1 = 1'b0;
    for (int r = 1; r <= 64; r++) begin
      @(negedge clock);
      if (r == 61) begin
        chk("t6_end15", endereco1, 4'hF);
        chk("t6_leds15", leds1, 4'h1);
      end
      if (r == 63) chk("t6_pronto", {3'b0, pronto1}, 4'h1);
    end
    chk("t6_ocupado_cai", {3'b0, ocupado1}, 4'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
